// File: rtl/kb_ascii_irq_pkg.sv
// Shared constants, prefix-state type and scan-code decode
// for the PS/2 set-2 to ASCII interrupt bridge.
package kb_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;

    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_ESC   = 8'h1B;
    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_UP    = 8'h11;
    localparam logic [7:0] ASC_DOWN  = 8'h12;
    localparam logic [7:0] ASC_LEFT  = 8'h13;
    localparam logic [7:0] ASC_RIGHT = 8'h14;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } kb_state_e;

    typedef struct packed {
        logic       valid;
        logic [7:0] ascii;
    } kb_dec_t;

    // Map one scan byte to ASCII; ext selects the E0-prefixed table.
    function automatic kb_dec_t kb_decode(input logic [7:0] sc,
                                          input logic       ext);
        kb_dec_t d;
        d.valid = 1'b1;
        d.ascii = 8'h00;
        if (ext) begin
            case (sc)
                8'h75:   d.ascii = ASC_UP;
                8'h72:   d.ascii = ASC_DOWN;
                8'h6B:   d.ascii = ASC_LEFT;
                8'h74:   d.ascii = ASC_RIGHT;
                8'h5A:   d.ascii = ASC_CR;
                default: d.valid = 1'b0;
            endcase
        end else begin
            case (sc)
                8'h45: d.ascii = 8'h30;
                8'h16: d.ascii = 8'h31;
                8'h1E: d.ascii = 8'h32;
                8'h26: d.ascii = 8'h33;
                8'h25: d.ascii = 8'h34;
                8'h2E: d.ascii = 8'h35;
                8'h36: d.ascii = 8'h36;
                8'h3D: d.ascii = 8'h37;
                8'h3E: d.ascii = 8'h38;
                8'h46: d.ascii = 8'h39;
                8'h1C: d.ascii = 8'h41;
                8'h32: d.ascii = 8'h42;
                8'h21: d.ascii = 8'h43;
                8'h23: d.ascii = 8'h44;
                8'h24: d.ascii = 8'h45;
                8'h2B: d.ascii = 8'h46;
                8'h34: d.ascii = 8'h47;
                8'h33: d.ascii = 8'h48;
                8'h43: d.ascii = 8'h49;
                8'h3B: d.ascii = 8'h4A;
                8'h42: d.ascii = 8'h4B;
                8'h4B: d.ascii = 8'h4C;
                8'h3A: d.ascii = 8'h4D;
                8'h31: d.ascii = 8'h4E;
                8'h44: d.ascii = 8'h4F;
                8'h4D: d.ascii = 8'h50;
                8'h15: d.ascii = 8'h51;
                8'h2D: d.ascii = 8'h52;
                8'h1B: d.ascii = 8'h53;
                8'h2C: d.ascii = 8'h54;
                8'h3C: d.ascii = 8'h55;
                8'h2A: d.ascii = 8'h56;
                8'h1D: d.ascii = 8'h57;
                8'h22: d.ascii = 8'h58;
                8'h35: d.ascii = 8'h59;
                8'h1A: d.ascii = 8'h5A;
                8'h5A: d.ascii = ASC_CR;
                8'h76: d.ascii = ASC_ESC;
                8'h29: d.ascii = ASC_SPACE;
                default: d.valid = 1'b0;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/kb_ascii_irq_if.sv
// Scan-byte input and PicoBlaze-facing byte stream
// bundled as one interface.
interface kb_ascii_irq_if;

    logic [7:0] scan_code;
    logic       scan_done_tick;
    logic       DoRead;
    logic [7:0] ascii_code;
    logic       interrupt;
    logic       overflow;

    modport master (
        output scan_code,
        output scan_done_tick,
        output DoRead,
        input  ascii_code,
        input  interrupt,
        input  overflow
    );

    modport slave (
        input  scan_code,
        input  scan_done_tick,
        input  DoRead,
        output ascii_code,
        output interrupt,
        output overflow
    );

endinterface

// File: rtl/kb_ascii_irq_fifo.sv
// Small synchronous FIFO with registered head and
// non-empty flag, plus a sticky drop flag.
module kb_code_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] head,
    output logic       valid,
    output logic       overflow
);

    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_next;
    logic [AW:0]   cnt_q;
    logic [AW:0]   cnt_n;
    logic [7:0]    head_n;
    logic          empty;
    logic          full;
    logic          do_pop;
    logic          do_push;
    logic          drop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_FULL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign rd_next = rd_ptr + PTR_ONE;

    // Next occupancy and the value the head register must hold next.
    always_comb begin
        cnt_n  = cnt_q;
        head_n = head;
        if (do_push && !do_pop) begin
            cnt_n = cnt_q + CNT_ONE;
        end else if (do_pop && !do_push) begin
            cnt_n = cnt_q - CNT_ONE;
        end
        if (cnt_n == '0) begin
            head_n = 8'h00;
        end else if (do_pop) begin
            head_n = (cnt_q > CNT_ONE) ? mem[rd_next] : din;
        end else if (empty) begin
            head_n = din;
        end
    end

    // Pointers, count, registered head/valid and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt_q    <= '0;
            head     <= 8'h00;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_next;
            cnt_q <= cnt_n;
            head  <= head_n;
            valid <= (cnt_n != '0);
            if (drop) overflow <= 1'b1;
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/kb_ascii_irq.sv
// Set-2 prefix tracking and decode in front of a code FIFO
// that feeds the PicoBlaze interrupt/in_port path.
module kb_ascii_irq
    import kb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic           clk,
    input logic           reset,
    kb_ascii_irq_if.slave bus
);

    kb_state_e state;
    kb_state_e state_n;
    kb_dec_t   dec;
    logic      push;

    // Prefix state machine and push decision for the current byte.
    always_comb begin
        state_n = state;
        push    = 1'b0;
        dec     = kb_decode(bus.scan_code, state == EXT);
        if (bus.scan_done_tick) begin
            case (state)
                IDLE: begin
                    if (bus.scan_code == SC_BREAK) begin
                        state_n = BRK;
                    end else if (bus.scan_code == SC_EXT) begin
                        state_n = EXT;
                    end else begin
                        push = dec.valid;
                    end
                end
                EXT: begin
                    if (bus.scan_code == SC_BREAK) begin
                        state_n = EXT_BRK;
                    end else if (bus.scan_code != SC_EXT) begin
                        push    = dec.valid;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Prefix state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    kb_code_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (bus.DoRead),
        .din      (dec.ascii),
        .head     (bus.ascii_code),
        .valid    (bus.interrupt),
        .overflow (bus.overflow)
    );

endmodule

// File: doc/kb_ascii_irq.md
# kb_ascii_irq

Converts PS/2 set-2 scan codes from the keyboard receiver into ASCII/control codes and presents them to the PicoBlaze as an interrupt-driven byte stream. It sits between the PS/2 receiver and the top-level `ascii_reg` / PicoBlaze `in_port`. It drives `interrupt` and pops one entry per `interrupt_ack` (`DoRead`). It filters break sequences and extended prefixes, and buffers bursts in a small FIFO so keystrokes are not lost while the PicoBlaze services the RTC or VGA.

## Interface
- `DEPTH`, default 4, FIFO entries; power of two, ≥2.
- `clk` input 1: system clock, 100 MHz.
- `reset` input 1: asynchronous, active-high; clears all state.
- `scan_code` input 8: byte from the PS/2 receiver, valid when `scan_done_tick` is high.
- `scan_done_tick` input 1: one-cycle strobe per received byte.
- `DoRead` input 1: PicoBlaze `interrupt_ack`, one-cycle pulse; pops the FIFO head.
- `ascii_code` output 8: FIFO head; 0x00 when empty.
- `interrupt` output 1: high while the FIFO is non-empty.
- `overflow` output 1: sticky; set when a decoded code is dropped because the FIFO is full.

## Operation
- **Prefix FSM states:**
  - `IDLE`: F0 → `BRK`; E0 → `EXT`; else decode as normal.
  - `EXT`: F0 → `EXT_BRK`; else decode as extended, → `IDLE`.
  - `BRK`: any byte is discarded, → `IDLE`.
  - `EXT_BRK`: any byte is discarded, → `IDLE`.
  - A second E0 while in `EXT` stays in `EXT`.
- **Normal decode:**
  - 0x45,16,1E,26,25,2E,36,3D,3E,46 → '0'..'9' (0x30–0x39).
  - Set-2 letters A–Z → uppercase 0x41–0x5A.
  - 0x5A → 0x0D (Enter); 0x76 → 0x1B (Esc); 0x29 → 0x20 (Space).
- **Extended decode:**
  - E0 75 → 0x11 (up); E0 72 → 0x12 (down); E0 6B → 0x13 (left); E0 74 → 0x14 (right).
  - E0 5A → 0x0D.
- Unmapped codes, normal or extended, are discarded: no push and no overflow.
- Typematic repeats push again; no auto-repeat suppression.
- Push happens on the same edge as `scan_done_tick` when the decode is valid.
- **FIFO:** `DEPTH` entries with wrapping read and write pointers and a count of width clog2(`DEPTH`)+1.
- Push when full drops the new code and sets `overflow`. The head and count are unchanged.
- `DoRead` while empty is ignored.
- Simultaneous push and pop:
  - When full: both occur, count unchanged, no overflow.
  - When empty: the push lands and the pop is ignored.
- **Reset values:** FSM=`IDLE`, pointers=0, count=0, `interrupt`=0, `ascii_code`=0x00, `overflow`=0.
- `reset` mid-sequence (e.g. after E0) abandons the prefix.

## Timing
- Latency from `scan_done_tick` at edge N: entry visible, `interrupt`=1 and `ascii_code` valid after edge N, i.e. in cycle N+1.
- `interrupt` and `ascii_code` are registered outputs, glitch-free, stable until a pop.
- A `DoRead` pulse at edge M takes effect in cycle M+1:
  - Either the next entry appears at the head, or `interrupt`=0 and `ascii_code`=0x00 if the FIFO is now empty.
- PS/2 bytes arrive ≥~1 ms apart, so there is no back-to-back tick requirement. The design must still accept ticks on consecutive cycles.
- `DoRead` is level-sampled once per cycle. A pulse longer than one cycle pops once per cycle held.

## Structure
- **Package `kb_pkg`:**
  - Constants `SC_BREAK`=8'hF0 and `SC_EXT`=8'hE0.
  - ASCII control constants 0x0D, 0x1B, 0x11–0x14.
  - State enum {`IDLE`, `EXT`, `BRK`, `EXT_BRK`}.
  - A decode function (scan, ext) → {valid, ascii}.
- **Sub-module `kb_code_fifo`:** parameterised synchronous FIFO with push/pop/full/empty/head and registered head. The top holds only the FSM and decode.

## Test plan
- Reset release, then tick 0x16 → cycle after: `interrupt`=1, `ascii_code`=0x31. `DoRead` pulse → `interrupt`=0, `ascii_code`=0x00.
- Sequence 1C, F0, 1C → exactly one entry, 0x41. The break byte pushes nothing.
- Sequence E0 75, E0 F0 75, E0 6B → entries 0x11 then 0x13. Pop twice and check order and the final `interrupt`=0.
- Push 5 digits '1'..'5' with `DEPTH`=4 and no reads → `overflow`=1. Pops return 0x31–0x34 and '5' is lost.
- FIFO full, with tick 0x26 and `DoRead` on the same cycle → count stays 4, `overflow` stays 0, and the tail is 0x33.
- Assert `reset` after E0 and before 75, then tick 0x75 → decoded as normal 0x75, which is unmapped, so no entry and `interrupt`=0.
